// File: rtl/uart_prog_mem.sv
// uart_prog_mem: program/data memory for the accumulator core, loaded from a UART byte stream.
// Ports:
//   clk, reset              clock and asynchronous active-high reset
//   rx_valid, rx_data       received byte strobe and value
//   core_reset              holds the core in reset whenever the loader is not in RUN
//   loading                 high while a frame (length, data, checksum) is in progress
//   load_done               one-cycle pulse when a frame's checksum matches
//   err                     sticky frame error, cleared by the next start byte
//   PC_ADRR, PC_R           instruction read port (combinational)
//   operand_addr, operand   operand read port (combinational), also the core write address
//   write, wdata            core write-back, honoured only in RUN
module uart_prog_mem #(
    parameter int word_width = 8,
    parameter logic [word_width-1:0] START_BYTE = 8'hA5,
    localparam int AW = $clog2(word_width)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_valid,
    input  logic [word_width-1:0] rx_data,
    output logic                  core_reset,
    output logic                  loading,
    output logic                  load_done,
    output logic                  err,
    input  logic [AW-1:0]         PC_ADRR,
    output logic [word_width-1:0] PC_R,
    input  logic [AW-1:0]         operand_addr,
    output logic [word_width-1:0] operand,
    input  logic                  write,
    input  logic [word_width-1:0] wdata
);
    typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN} state_t;

    localparam logic [word_width-1:0] DEPTH = word_width[word_width-1:0];

    state_t                state, state_nx;
    logic [AW:0]           len, idx;
    logic [word_width-1:0] csum;
    logic [word_width-1:0] mem [word_width];
    logic                  start, len_ok, last, csum_ok;

    always_comb begin
        start    = rx_data == START_BYTE;
        len_ok   = rx_data != '0 && rx_data <= DEPTH;
        last     = idx + (AW+1)'(1) == len;
        csum_ok  = rx_data == csum;
        loading  = state == LEN || state == DATA || state == CSUM;
        state_nx = state;
        if (rx_valid) begin
            case (state)
                IDLE, RUN: state_nx = start ? LEN : state;
                LEN:       state_nx = len_ok ? DATA : IDLE;
                DATA:      state_nx = last ? CSUM : DATA;
                CSUM:      state_nx = csum_ok ? RUN : IDLE;
                default:   state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            core_reset <= 1'b1;
            load_done  <= 1'b0;
            err        <= 1'b0;
            len        <= '0;
            idx        <= '0;
            csum       <= '0;
        end else begin
            state      <= state_nx;
            // registered from the next state so it drops together with load_done
            core_reset <= state_nx != RUN;
            load_done  <= rx_valid && state == CSUM && csum_ok;
            if (rx_valid) begin
                case (state)
                    IDLE, RUN: if (start) begin
                        err  <= 1'b0;
                        idx  <= '0;
                        csum <= '0;
                    end
                    LEN: if (len_ok) len <= rx_data[AW:0];
                         else err <= 1'b1;
                    DATA: begin
                        idx  <= idx + (AW+1)'(1);
                        csum <= csum ^ rx_data;
                    end
                    CSUM: if (!csum_ok) err <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // loader writes only in DATA and core writes only in RUN, so they never collide
    always_ff @(posedge clk) begin
        if (rx_valid && state == DATA) mem[idx[AW-1:0]] <= rx_data;
        else if (write && state == RUN) mem[operand_addr] <= wdata;
    end

    assign PC_R    = mem[PC_ADRR];
    assign operand = mem[operand_addr];
endmodule
